cart_rom_port: RTL and testbench

Bridges the cartridge mapper's level-style ROM strobes (ROM_A/ROM_RD/ROM_WRL/ROM_WRH) to the SDRAM controller's req/ack port. It turns each bus access into exactly one memory transaction and returns read data with a wait indication. It also keeps a single-word sequential prefetch buffer, so the next ROM word is often already available. It sits directly downstream of the cartridge mapper, between the mapper and SDRAM.

---
 rtl/cart_rom_port.sv | 262 ++++++++++++++++++++++++++
 tb/tb_cart_rom_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_rom_port.sv
// -----------------------------------------------------------------------------
// cart_rom_port
//
// Bridges the cartridge mapper's level-style ROM strobes to an SDRAM req/ack
// port. Each bus access becomes exactly one memory transaction. A one-word
// sequential prefetch buffer lets the next ROM word often complete without
// touching SDRAM.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   rom_a_i     word address from the mapper
//   rom_do_i    write data from the mapper
//   rom_rd_i    read strobe (level, held for the whole access)
//   rom_wrl_i   low byte write strobe (level)
//   rom_wrh_i   high byte write strobe (level)
//   rom_di_o    read data to the mapper, holds between accesses
//   rom_wait_o  high while an access is active and not yet complete
//   mem_addr_o  SDRAM word address
//   mem_data_o  SDRAM write data
//   mem_be_o    byte enables {H,L}, 2'b11 for reads
//   mem_we_o    1 = write transaction
//   mem_req_o   request level, held until mem_ack_i
//   mem_ack_i   one-cycle completion pulse
//   mem_q_i     read data, valid with mem_ack_i
// -----------------------------------------------------------------------------
module cart_rom_port #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [23:1] rom_a_i,
  input  logic [15:0] rom_do_i,
  input  logic        rom_rd_i,
  input  logic        rom_wrl_i,
  input  logic        rom_wrh_i,
  output logic [15:0] rom_di_o,
  output logic        rom_wait_o,
  output logic [23:1] mem_addr_o,
  output logic [15:0] mem_data_o,
  output logic [1:0]  mem_be_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic        mem_ack_i,
  input  logic [15:0] mem_q_i
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD_REQ = 3'd1;
  localparam logic [2:0] S_WR_REQ = 3'd2;
  localparam logic [2:0] S_PF_REQ = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        strb_q, rd_q;
  logic [23:1] a_q;
  logic [15:0] rom_di_q, rom_di_d;
  logic [23:1] mem_addr_q, mem_addr_d;
  logic [15:0] mem_data_q, mem_data_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_req_q, mem_req_d;
  logic        pf_valid_q, pf_valid_d;
  logic [23:1] pf_addr_q, pf_addr_d;
  logic [15:0] pf_data_q, pf_data_d;
  logic        last_rd_q, last_rd_d;
  logic [23:1] last_addr_q, last_addr_d;
  logic        pend_q, pend_d;
  logic        pend_we_q, pend_we_d;
  logic [1:0]  pend_be_q, pend_be_d;
  logic [23:1] pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;

  logic        strb, start, cur_we;
  logic [1:0]  cur_be;
  logic        use_pend, do_access;
  logic        acc_we, acc_hit;
  logic [1:0]  acc_be;
  logic [23:1] acc_addr, next_addr;
  logic [15:0] acc_data;

  assign strb   = rom_rd_i | rom_wrl_i | rom_wrh_i;
  // New access: strobe rising edge, or an address step during a held read (burst).
  assign start  = (strb & ~strb_q) | (rom_rd_i & rd_q & (rom_a_i != a_q));
  // Any write strobe wins over a simultaneous read strobe.
  assign cur_we = rom_wrl_i | rom_wrh_i;
  assign cur_be = {rom_wrh_i, rom_wrl_i};
  // 23-bit arithmetic wraps 7FFFFF to 000000 naturally.
  assign next_addr = last_addr_q + 23'd1;

  // An access captured during a prefetch is replayed from IDLE, one cycle
  // after the prefetch ACK, so MEM_REQ always has a low cycle in between.
  assign use_pend = (state_q == S_IDLE) && pend_q;
  assign acc_we   = use_pend ? pend_we_q   : cur_we;
  assign acc_be   = use_pend ? pend_be_q   : cur_be;
  assign acc_addr = use_pend ? pend_addr_q : rom_a_i;
  assign acc_data = use_pend ? pend_data_q : rom_do_i;
  assign acc_hit  = PREFETCH && pf_valid_q && (acc_addr == pf_addr_q) && !acc_we;

  always_comb begin
    state_d     = state_q;
    rom_di_d    = rom_di_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    mem_req_d   = mem_req_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    last_rd_d   = last_rd_q;
    last_addr_d = last_addr_q;
    pend_d      = pend_q;
    pend_we_d   = pend_we_q;
    pend_be_d   = pend_be_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    do_access   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          do_access = 1'b1;
          pend_d    = 1'b0;
        end else if (start) begin
          do_access = 1'b1;
        end
      end
      S_RD_REQ: begin
        if (mem_ack_i) begin
          rom_di_d  = mem_q_i;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_WR_REQ: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_PF_REQ: begin
        if (mem_ack_i) begin
          mem_req_d  = 1'b0;
          pf_addr_d  = mem_addr_q;
          pf_data_d  = mem_q_i;
          pf_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
        // The prefetch is never aborted; a new access waits behind it.
        if (start) begin
          pend_d      = 1'b1;
          pend_we_d   = cur_we;
          pend_be_d   = cur_be;
          pend_addr_d = rom_a_i;
          pend_data_d = rom_do_i;
        end
      end
      S_DONE: begin
        if (start) begin
          do_access = 1'b1;
        end else if (!strb) begin
          if (PREFETCH && last_rd_q && !(pf_valid_q && (pf_addr_q == next_addr))) begin
            state_d    = S_PF_REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_be_d   = 2'b11;
            mem_addr_d = next_addr;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_access) begin
      if (acc_we) begin
        state_d    = S_WR_REQ;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b1;
        mem_be_d   = acc_be;
        mem_addr_d = acc_addr;
        mem_data_d = acc_data;
        last_rd_d  = 1'b0;
        // Keep the buffer coherent with a write to the prefetched word.
        if (pf_valid_q && (pf_addr_q == acc_addr)) begin
          pf_valid_d = 1'b0;
        end
      end else begin
        last_rd_d   = 1'b1;
        last_addr_d = acc_addr;
        if (acc_hit) begin
          rom_di_d   = pf_data_q;
          pf_valid_d = 1'b0;
          state_d    = S_DONE;
        end else begin
          state_d    = S_RD_REQ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = 2'b11;
          mem_addr_d = acc_addr;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      strb_q      <= 1'b0;
      rd_q        <= 1'b0;
      a_q         <= '0;
      rom_di_q    <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= '0;
      last_rd_q   <= 1'b0;
      last_addr_q <= '0;
      pend_q      <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_be_q   <= '0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      strb_q      <= strb;
      rd_q        <= rom_rd_i;
      a_q         <= rom_a_i;
      rom_di_q    <= rom_di_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      mem_req_q   <= mem_req_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      last_rd_q   <= last_rd_d;
      last_addr_q <= last_addr_d;
      pend_q      <= pend_d;
      pend_we_q   <= pend_we_d;
      pend_be_q   <= pend_be_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign rom_wait_o = strb & (state_q != S_DONE);
  assign rom_di_o   = rom_di_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_be_o   = mem_be_q;
  assign mem_we_o   = mem_we_q;
  assign mem_req_o  = mem_req_q;

endmodule

// File: tb/tb_cart_rom_port.sv
module tb_cart_rom_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:1] rom_a = '0;
  logic [15:0] rom_do = '0;
  logic        rom_rd = 1'b0, rom_wrl = 1'b0, rom_wrh = 1'b0;
  logic [15:0] rom_di;
  logic        rom_wait;
  logic [23:1] mem_addr;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        mem_we, mem_req;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_q = '0;

  cart_rom_port #(.PREFETCH(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rom_a_i(rom_a), .rom_do_i(rom_do), .rom_rd_i(rom_rd),
    .rom_wrl_i(rom_wrl), .rom_wrh_i(rom_wrh),
    .rom_di_o(rom_di), .rom_wait_o(rom_wait),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_be_o(mem_be),
    .mem_we_o(mem_we), .mem_req_o(mem_req),
    .mem_ack_i(mem_ack), .mem_q_i(mem_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] data;
  } txn_t;

  txn_t sb[$];
  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int hs_base;

  // Count completed handshakes on the memory port.
  always @(posedge clk) if (mem_req && mem_ack) hs_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_rd(input logic [22:0] a);
    txn_t t;
    t.addr = a; t.we = 1'b0; t.be = 2'b11; t.data = 16'h0;
    sb.push_back(t);
  endtask

  task automatic push_wr(input logic [22:0] a, input logic [1:0] be, input logic [15:0] d);
    txn_t t;
    t.addr = a; t.we = 1'b1; t.be = be; t.data = d;
    sb.push_back(t);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Act as the SDRAM: wait for a request, hold it dly cycles, then compare
  // the request fields with the scoreboard head and pulse ACK.
  task automatic serve(input string tag, input logic [15:0] q, input int dly);
    bit   ok;
    txn_t e;
    wait_req(ok);
    chk({tag, "_req_seen"}, {31'd0, ok}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
    if (ok && sb.size() != 0) begin
      e = sb.pop_front();
      repeat (dly) tick();
      chk({tag, "_addr"}, {9'd0, mem_addr}, {9'd0, e.addr});
      chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, e.we});
      chk({tag, "_be"}, {30'd0, mem_be}, {30'd0, e.be});
      if (e.we) chk({tag, "_data"}, {16'd0, mem_data}, {16'd0, e.data});
      mem_ack = 1'b1;
      mem_q   = q;
      tick();
      mem_ack = 1'b0;
      mem_q   = 16'h0;
    end
    $display("txn %s: addr=0x%06h we=%0d be=%b q=0x%04h", tag, e.addr, e.we, e.be, q);
  endtask

  initial begin
    bit ok;
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Reset state
    #2;
    chk("rst_rom_di", {16'd0, rom_di}, 32'h0);
    chk("rst_wait", {31'd0, rom_wait}, 32'h0);
    chk("rst_req", {31'd0, mem_req}, 32'h0);
    chk("rst_we", {31'd0, mem_we}, 32'h0);
    chk("rst_be", {30'd0, mem_be}, 32'h0);
    chk("rst_addr", {9'd0, mem_addr}, 32'h0);
    chk("rst_data", {16'd0, mem_data}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Read miss, then prefetch of the next word
    rom_a = 23'h000100; rom_rd = 1'b1;
    #1;
    chk("miss_wait_comb", {31'd0, rom_wait}, 32'd1);
    push_rd(23'h000100);
    serve("miss", 16'h1234, 2);
    chk("miss_rom_di", {16'd0, rom_di}, 32'h1234);
    chk("miss_wait_low", {31'd0, rom_wait}, 32'd0);
    rom_rd = 1'b0;
    push_rd(23'h000101);
    serve("pf101", 16'hBEEF, 1);
    chk("req_drop_after_ack", {31'd0, mem_req}, 32'd0);

    // Sequential hit from the buffer
    tick();
    hs_base = hs_cnt;
    rom_a = 23'h000101; rom_rd = 1'b1;
    tick();
    chk("hit_rom_di", {16'd0, rom_di}, 32'hBEEF);
    chk("hit_wait", {31'd0, rom_wait}, 32'd0);
    chk("hit_no_req", {31'd0, mem_req}, 32'd0);
    chk("hit_no_hs", hs_cnt - hs_base, 32'd0);
    $display("txn hit: addr=0x000101 rom_di=0x%04h", rom_di);
    rom_rd = 1'b0;
    push_rd(23'h000102);
    serve("pf102", 16'h5555, 1);

    // High-byte write to the buffered word, then a read of it
    tick();
    rom_a = 23'h000102; rom_do = 16'hAB00; rom_wrh = 1'b1;
    push_wr(23'h000102, 2'b10, 16'hAB00);
    serve("wrh", 16'h0000, 1);
    chk("wr_rom_di_kept", {16'd0, rom_di}, 32'hBEEF);
    chk("wr_wait_low", {31'd0, rom_wait}, 32'd0);
    rom_wrh = 1'b0;
    tick(); tick(); tick();
    chk("wr_no_prefetch", {31'd0, mem_req}, 32'd0);
    rom_rd = 1'b1;
    push_rd(23'h000102);
    serve("coh_rd", 16'h7777, 1);
    chk("coh_rom_di", {16'd0, rom_di}, 32'h7777);
    rom_rd = 1'b0;
    push_rd(23'h000103);
    serve("pf103", 16'h3333, 1);

    // Collision: read arrives during an outstanding prefetch
    tick();
    rom_a = 23'h000180; rom_rd = 1'b1;
    push_rd(23'h000180);
    serve("rd180", 16'h1111, 1);
    rom_rd = 1'b0;
    push_rd(23'h000181);
    tick();
    wait_req(ok);
    chk("col_pf_req", {31'd0, ok}, 32'd1);
    hs_base = hs_cnt;
    rom_a = 23'h000200; rom_rd = 1'b1;
    tick(); tick(); tick();
    chk("col_wait_held", {31'd0, rom_wait}, 32'd1);
    serve("pf181", 16'h2222, 0);
    chk("col_wait_after_pf", {31'd0, rom_wait}, 32'd1);
    chk("col_req_gap", {31'd0, mem_req}, 32'd0);
    push_rd(23'h000200);
    serve("rd200", 16'h4444, 1);
    chk("col_rom_di", {16'd0, rom_di}, 32'h4444);
    chk("col_wait_low", {31'd0, rom_wait}, 32'd0);
    chk("col_hs_count", hs_cnt - hs_base, 32'd2);
    rom_rd = 1'b0;
    push_rd(23'h000201);
    serve("pf201", 16'h4545, 1);

    // Wrap-around prefetch
    tick();
    rom_a = 23'h7FFFFF; rom_rd = 1'b1;
    push_rd(23'h7FFFFF);
    serve("rdtop", 16'h0F0F, 1);
    rom_rd = 1'b0;
    push_rd(23'h000000);
    serve("pfwrap", 16'hF0F0, 1);

    // Burst: address steps while ROM_RD stays high
    tick();
    rom_a = 23'h000010; rom_rd = 1'b1;
    push_rd(23'h000010);
    serve("burst10", 16'hA010, 1);
    chk("burst10_rom_di", {16'd0, rom_di}, 32'hA010);
    chk("burst10_wait", {31'd0, rom_wait}, 32'd0);
    rom_a = 23'h000011;
    tick();
    chk("burst11_wait_high", {31'd0, rom_wait}, 32'd1);
    push_rd(23'h000011);
    serve("burst11", 16'hA011, 1);
    chk("burst11_rom_di", {16'd0, rom_di}, 32'hA011);
    chk("burst11_wait", {31'd0, rom_wait}, 32'd0);
    rom_a = 23'h000012;
    tick();
    chk("burst12_wait_high", {31'd0, rom_wait}, 32'd1);
    push_rd(23'h000012);
    serve("burst12", 16'hA012, 1);
    chk("burst12_rom_di", {16'd0, rom_di}, 32'hA012);
    rom_rd = 1'b0;
    push_rd(23'h000013);
    serve("pf13", 16'hA013, 1);

    // Reset in the middle of a read request
    tick();
    rom_a = 23'h000300; rom_rd = 1'b1;
    tick();
    wait_req(ok);
    chk("rstmid_req_up", {31'd0, ok}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_rom_di", {16'd0, rom_di}, 32'd0);
    rom_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    hs_base = hs_cnt;
    mem_ack = 1'b1; mem_q = 16'hDEAD;
    tick();
    mem_ack = 1'b0; mem_q = 16'h0;
    tick();
    chk("stray_rom_di", {16'd0, rom_di}, 32'd0);
    chk("stray_req", {31'd0, mem_req}, 32'd0);
    chk("stray_wait", {31'd0, rom_wait}, 32'd0);
    chk("stray_no_hs", hs_cnt - hs_base, 32'd0);
    $display("txn reset_mid: stray ack rom_di=0x%04h", rom_di);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
